// File: rtl/wb_req_pkg.sv
// Shared definitions for the Wishbone request master: cycle-type codes,
// FSM state encoding and small sizing/cycle-type helpers.
package wb_req_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      WLOAD,
      BUS
   } state_t;

   function automatic int beat_w(input int maxBl);
      return $clog2(maxBl) + 1;
   endfunction

   // Single-beat transfers are classic cycles; bursts end with CTI_END.
   function automatic logic [2:0] cti_for(input logic burst, input logic last);
      if (!burst) begin
         return CTI_CLASSIC;
      end else if (last) begin
         return CTI_END;
      end else begin
         return CTI_INCR;
      end
   endfunction

endpackage

// File: rtl/wb_req_wdog.sv
// Ack-timeout watchdog: counts strobed cycles without an acknowledge and
// flags the cycle in which the TIMEOUT-th unacknowledged cycle is reached.
module wb_req_wdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // An ack in the threshold cycle clears the count instead of expiring.
   assign expire_o = en_i && !clr_i && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_req_master.sv
// Wishbone master turning a request stream plus write-data stream into
// classic / incrementing-burst cycles, with a read response stream.
module wb_req_master
   import wb_req_pkg::*;
#(
   parameter int APP_AW  = 26,
   parameter int dw      = 32,
   parameter int MAX_BL  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                      wb_clk,
   input  logic                      wb_rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [APP_AW-1:0]         req_addr,
   input  logic [beat_w(MAX_BL)-1:0] req_bl,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [dw-1:0]             wr_data,
   input  logic [dw/8-1:0]           wr_sel,
   output logic                      rd_valid,
   output logic [dw-1:0]             rd_data,
   output logic                      rd_last,
   output logic                      err,
   output logic                      wb_cyc,
   output logic                      wb_stb,
   output logic                      wb_we,
   output logic [APP_AW-1:0]         wb_addr,
   output logic [dw-1:0]             wb_dati,
   output logic [dw/8-1:0]           wb_sel,
   output logic [2:0]                wb_cti,
   input  logic                      wb_ack,
   input  logic [dw-1:0]             wb_dato
);

   localparam int BW = beat_w(MAX_BL);
   localparam int SW = dw / 8;

   state_t              state_q, state_d;
   logic [BW-1:0]       beats_q, beats_d;
   logic                burst_q, burst_d;
   logic                reqReady_q, reqReady_d;
   logic                wrReady_q, wrReady_d;
   logic                rdValid_q, rdValid_d;
   logic [dw-1:0]       rdData_q, rdData_d;
   logic                rdLast_q, rdLast_d;
   logic                err_q, err_d;
   logic                cyc_q, cyc_d;
   logic                stb_q, stb_d;
   logic                we_q, we_d;
   logic [APP_AW-1:0]   addr_q, addr_d;
   logic [dw-1:0]       dati_q, dati_d;
   logic [SW-1:0]       sel_q, sel_d;
   logic [2:0]          cti_q, cti_d;
   logic [BW-1:0]       reqBeats;
   logic                expire;

   wb_req_wdog #(
      .TIMEOUT(TIMEOUT)
   ) u_wdog (
      .clk_i   (wb_clk),
      .rst_i   (wb_rst),
      .clr_i   ((state_q != BUS) || wb_ack),
      .en_i    (state_q == BUS),
      .expire_o(expire)
   );

   assign reqBeats = (req_bl == '0) ? BW'(1) : req_bl;

   always_comb begin
      state_d    = state_q;
      beats_d    = beats_q;
      burst_d    = burst_q;
      reqReady_d = reqReady_q;
      wrReady_d  = wrReady_q;
      rdValid_d  = 1'b0;
      rdData_d   = rdData_q;
      rdLast_d   = 1'b0;
      err_d      = 1'b0;
      cyc_d      = cyc_q;
      stb_d      = stb_q;
      we_d       = we_q;
      addr_d     = addr_q;
      dati_d     = dati_q;
      sel_d      = sel_q;
      cti_d      = cti_q;

      case (state_q)
         IDLE: begin
            reqReady_d = 1'b1;
            if (req_valid && reqReady_q) begin
               reqReady_d = 1'b0;
               cyc_d      = 1'b1;
               we_d       = req_we;
               addr_d     = req_addr;
               beats_d    = reqBeats;
               burst_d    = (reqBeats != BW'(1));
               cti_d      = cti_for(reqBeats != BW'(1), reqBeats == BW'(1));
               if (req_we) begin
                  state_d   = WLOAD;
                  wrReady_d = 1'b1;
                  stb_d     = 1'b0;
               end else begin
                  state_d = BUS;
                  stb_d   = 1'b1;
                  sel_d   = '1;
               end
            end
         end

         WLOAD: begin
            if (wr_valid && wrReady_q) begin
               dati_d    = wr_data;
               sel_d     = wr_sel;
               wrReady_d = 1'b0;
               stb_d     = 1'b1;
               state_d   = BUS;
            end
         end

         BUS: begin
            if (wb_ack) begin
               if (!we_q) begin
                  rdValid_d = 1'b1;
                  rdData_d  = wb_dato;
                  rdLast_d  = (beats_q == BW'(1));
               end
               if (beats_q == BW'(1)) begin
                  state_d    = IDLE;
                  reqReady_d = 1'b1;
                  cyc_d      = 1'b0;
                  stb_d      = 1'b0;
                  we_d       = 1'b0;
                  sel_d      = '0;
                  cti_d      = CTI_CLASSIC;
               end else begin
                  beats_d = beats_q - 1'b1;
                  addr_d  = addr_q + APP_AW'(SW);
                  cti_d   = cti_for(burst_q, beats_q == BW'(2));
                  if (we_q) begin
                     state_d   = WLOAD;
                     stb_d     = 1'b0;
                     wrReady_d = 1'b1;
                  end
               end
            end else if (expire) begin
               // Abort: remaining beats are dropped and no rd_last is issued.
               state_d    = IDLE;
               reqReady_d = 1'b1;
               err_d      = 1'b1;
               cyc_d      = 1'b0;
               stb_d      = 1'b0;
               we_d       = 1'b0;
               sel_d      = '0;
               cti_d      = CTI_CLASSIC;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_q    <= IDLE;
         beats_q    <= '0;
         burst_q    <= 1'b0;
         reqReady_q <= 1'b0;
         wrReady_q  <= 1'b0;
         rdValid_q  <= 1'b0;
         rdData_q   <= '0;
         rdLast_q   <= 1'b0;
         err_q      <= 1'b0;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         dati_q     <= '0;
         sel_q      <= '0;
         cti_q      <= '0;
      end else begin
         state_q    <= state_d;
         beats_q    <= beats_d;
         burst_q    <= burst_d;
         reqReady_q <= reqReady_d;
         wrReady_q  <= wrReady_d;
         rdValid_q  <= rdValid_d;
         rdData_q   <= rdData_d;
         rdLast_q   <= rdLast_d;
         err_q      <= err_d;
         cyc_q      <= cyc_d;
         stb_q      <= stb_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         dati_q     <= dati_d;
         sel_q      <= sel_d;
         cti_q      <= cti_d;
      end
   end

   assign req_ready = reqReady_q;
   assign wr_ready  = wrReady_q;
   assign rd_valid  = rdValid_q;
   assign rd_data   = rdData_q;
   assign rd_last   = rdLast_q;
   assign err       = err_q;
   assign wb_cyc    = cyc_q;
   assign wb_stb    = stb_q;
   assign wb_we     = we_q;
   assign wb_addr   = addr_q;
   assign wb_dati   = dati_q;
   assign wb_sel    = sel_q;
   assign wb_cti    = cti_q;

endmodule

// File: tb/tb_wb_req_master.sv
// Directed testbench for wb_req_master; the bench plays the Wishbone slave
// and drives/samples on the falling clock edge.
module tb_wb_req_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [25:0] req_addr;
   logic [3:0]  req_bl;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic [3:0]  wr_sel;
   logic        rd_valid, rd_last, err;
   logic [31:0] rd_data;
   logic        wb_cyc, wb_stb, wb_we, wb_ack;
   logic [25:0] wb_addr;
   logic [31:0] wb_dati, wb_dato;
   logic [3:0]  wb_sel;
   logic [2:0]  wb_cti;

   int nChecks = 0;
   int nFails  = 0;

   always #5 clk = ~clk;

   wb_req_master dut (
      .wb_clk(clk), .wb_rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_bl(req_bl),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_sel(wr_sel),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .err(err),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
      .wb_dati(wb_dati), .wb_sel(wb_sel), .wb_cti(wb_cti),
      .wb_ack(wb_ack), .wb_dato(wb_dato)
   );

   task automatic issueReq(input logic we, input logic [25:0] addr, input logic [3:0] bl);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_bl    = bl;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      nChecks++;
      if (req_ready !== 1'b0) begin nFails++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
      nChecks++;
      if ({wb_cyc, wb_stb, wb_we, wr_ready, rd_valid, rd_last, err} !== 7'b0) begin
         nFails++; $display("FAIL reset_ctrl: got %b expected 0000000", {wb_cyc, wb_stb, wb_we, wr_ready, rd_valid, rd_last, err});
      end
      nChecks++;
      if ({wb_addr, wb_sel, wb_cti} !== 33'b0) begin nFails++; $display("FAIL reset_bus: addr %h sel %h cti %b expected 0", wb_addr, wb_sel, wb_cti); end
      rst = 1'b0;
      @(negedge clk);
      nChecks++;
      if (req_ready !== 1'b1) begin nFails++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
   endtask

   task automatic test_single_read();
      issueReq(1'b0, 26'h100, 4'd1);
      nChecks++;
      if ({wb_cyc, wb_stb, wb_we, req_ready} !== 4'b1100) begin
         nFails++; $display("FAIL single_ctrl: cyc/stb/we/rdy %b expected 1100", {wb_cyc, wb_stb, wb_we, req_ready});
      end
      nChecks++;
      if (wb_addr !== 26'h100 || wb_cti !== 3'b000 || wb_sel !== 4'hF) begin
         nFails++; $display("FAIL single_bus: addr %h cti %b sel %h expected 100/000/f", wb_addr, wb_cti, wb_sel);
      end
      @(negedge clk);
      nChecks++;
      if (wb_stb !== 1'b1 || rd_valid !== 1'b0) begin nFails++; $display("FAIL single_wait: stb %b rd_valid %b expected 1/0", wb_stb, rd_valid); end
      @(negedge clk);
      wb_ack  = 1'b1;
      wb_dato = 32'hDEADBEEF;
      @(negedge clk);
      wb_ack = 1'b0;
      nChecks++;
      if (rd_valid !== 1'b1 || rd_last !== 1'b1 || rd_data !== 32'hDEADBEEF) begin
         nFails++; $display("FAIL single_rd: valid %b last %b data %h expected 1/1/deadbeef", rd_valid, rd_last, rd_data);
      end
      nChecks++;
      if ({wb_cyc, wb_stb, req_ready} !== 3'b001) begin nFails++; $display("FAIL single_end: cyc/stb/rdy %b expected 001", {wb_cyc, wb_stb, req_ready}); end
      @(negedge clk);
      nChecks++;
      if (rd_valid !== 1'b0) begin nFails++; $display("FAIL single_rd_pulse: got %b expected 0", rd_valid); end
   endtask

   task automatic test_burst_read();
      logic [31:0] dat [4];
      logic [2:0]  expCti;
      dat[0] = 32'h11111111; dat[1] = 32'h22222222; dat[2] = 32'h33333333; dat[3] = 32'h44444444;
      issueReq(1'b0, 26'h200, 4'd4);
      for (int i = 0; i < 4; i++) begin
         expCti = (i < 3) ? 3'b010 : 3'b111;
         nChecks++;
         if (wb_stb !== 1'b1 || wb_addr !== 26'h200 + 26'(4 * i) || wb_cti !== expCti) begin
            nFails++; $display("FAIL burst_beat%0d: stb %b addr %h cti %b expected 1/%h/%b", i, wb_stb, wb_addr, wb_cti, 26'h200 + 26'(4 * i), expCti);
         end
         if (i > 0) begin
            nChecks++;
            if (rd_valid !== 1'b1 || rd_data !== dat[i-1] || rd_last !== 1'b0) begin
               nFails++; $display("FAIL burst_rd%0d: valid %b data %h last %b expected 1/%h/0", i - 1, rd_valid, rd_data, rd_last, dat[i-1]);
            end
         end
         wb_ack  = 1'b1;
         wb_dato = dat[i];
         @(negedge clk);
      end
      wb_ack = 1'b0;
      nChecks++;
      if (rd_valid !== 1'b1 || rd_data !== dat[3] || rd_last !== 1'b1) begin
         nFails++; $display("FAIL burst_rd3: valid %b data %h last %b expected 1/%h/1", rd_valid, rd_data, rd_last, dat[3]);
      end
      nChecks++;
      if (wb_cyc !== 1'b0 || req_ready !== 1'b1) begin nFails++; $display("FAIL burst_end: cyc %b rdy %b expected 0/1", wb_cyc, req_ready); end
      @(negedge clk);
   endtask

   task automatic test_burst_write();
      logic [31:0] wd [3];
      logic [3:0]  ws [3];
      logic [2:0]  wc [3];
      wd[0] = 32'hA0A0A0A0; wd[1] = 32'hB1B1B1B1; wd[2] = 32'hC2C2C2C2;
      ws[0] = 4'hF; ws[1] = 4'h3; ws[2] = 4'hC;
      wc[0] = 3'b010; wc[1] = 3'b010; wc[2] = 3'b111;
      issueReq(1'b1, 26'h300, 4'd3);
      for (int b = 0; b < 3; b++) begin
         nChecks++;
         if ({wb_cyc, wb_stb, wb_we, wr_ready} !== 4'b1011) begin
            nFails++; $display("FAIL wr_load%0d: cyc/stb/we/wrdy %b expected 1011", b, {wb_cyc, wb_stb, wb_we, wr_ready});
         end
         if (b == 1) begin
            for (int k = 0; k < 3; k++) begin
               wb_ack = (k == 1);
               @(negedge clk);
               nChecks++;
               if ({wb_cyc, wb_stb, wr_ready} !== 3'b101 || wb_addr !== 26'h304) begin
                  nFails++; $display("FAIL wr_gap%0d: cyc/stb/wrdy %b addr %h expected 101/304", k, {wb_cyc, wb_stb, wr_ready}, wb_addr);
               end
            end
            wb_ack = 1'b0;
         end
         wr_valid = 1'b1;
         wr_data  = wd[b];
         wr_sel   = ws[b];
         @(negedge clk);
         wr_valid = 1'b0;
         nChecks++;
         if (wb_stb !== 1'b1 || wb_dati !== wd[b] || wb_sel !== ws[b] || wb_addr !== 26'h300 + 26'(4 * b) || wb_cti !== wc[b]) begin
            nFails++; $display("FAIL wr_beat%0d: stb %b dati %h sel %h addr %h cti %b expected 1/%h/%h/%h/%b",
                               b, wb_stb, wb_dati, wb_sel, wb_addr, wb_cti, wd[b], ws[b], 26'h300 + 26'(4 * b), wc[b]);
         end
         wb_ack = 1'b1;
         @(negedge clk);
         wb_ack = 1'b0;
      end
      nChecks++;
      if ({wb_cyc, wb_stb, req_ready, rd_valid} !== 4'b0010) begin
         nFails++; $display("FAIL wr_end: cyc/stb/rdy/rdv %b expected 0010", {wb_cyc, wb_stb, req_ready, rd_valid});
      end
   endtask

   task automatic test_addr_wrap();
      issueReq(1'b0, 26'h3FFFFFC, 4'd2);
      nChecks++;
      if (wb_addr !== 26'h3FFFFFC) begin nFails++; $display("FAIL wrap_first: addr %h expected 3fffffc", wb_addr); end
      wb_ack  = 1'b1;
      wb_dato = 32'h0BADF00D;
      @(negedge clk);
      nChecks++;
      if (wb_addr !== 26'h0 || wb_cti !== 3'b111) begin nFails++; $display("FAIL wrap_second: addr %h cti %b expected 0/111", wb_addr, wb_cti); end
      wb_dato = 32'h12345678;
      @(negedge clk);
      wb_ack = 1'b0;
      nChecks++;
      if (rd_valid !== 1'b1 || rd_last !== 1'b1 || rd_data !== 32'h12345678 || wb_cyc !== 1'b0) begin
         nFails++; $display("FAIL wrap_end: valid %b last %b data %h cyc %b expected 1/1/12345678/0", rd_valid, rd_last, rd_data, wb_cyc);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int nHigh = 0;
      int sawBad = 0;
      issueReq(1'b0, 26'h40, 4'd1);
      for (int i = 0; i < 400 && wb_stb === 1'b1; i++) begin
         nHigh++;
         if (err !== 1'b0 || rd_valid !== 1'b0) sawBad++;
         @(negedge clk);
      end
      nChecks++;
      if (nHigh != 255) begin nFails++; $display("FAIL to_cycles: stb high %0d cycles expected 255", nHigh); end
      nChecks++;
      if (sawBad != 0) begin nFails++; $display("FAIL to_early: %0d cycles with err/rd_valid during stb expected 0", sawBad); end
      nChecks++;
      if ({err, wb_cyc, wb_stb, rd_valid, req_ready} !== 5'b10001) begin
         nFails++; $display("FAIL to_abort: err/cyc/stb/rdv/rdy %b expected 10001", {err, wb_cyc, wb_stb, rd_valid, req_ready});
      end
      @(negedge clk);
      nChecks++;
      if ({err, rd_valid, rd_last, req_ready} !== 4'b0001) begin
         nFails++; $display("FAIL to_after: err/rdv/last/rdy %b expected 0001", {err, rd_valid, rd_last, req_ready});
      end
   endtask

   task automatic test_timeout_ack_race();
      issueReq(1'b0, 26'h80, 4'd2);
      for (int i = 0; i < 254; i++) @(negedge clk);
      wb_ack  = 1'b1;
      wb_dato = 32'hCAFE0001;
      @(negedge clk);
      wb_dato = 32'hCAFE0002;
      nChecks++;
      if ({err, wb_stb, rd_valid, rd_last} !== 4'b0110 || wb_addr !== 26'h84 || rd_data !== 32'hCAFE0001) begin
         nFails++; $display("FAIL race_ack: err/stb/rdv/last %b addr %h data %h expected 0110/84/cafe0001",
                            {err, wb_stb, rd_valid, rd_last}, wb_addr, rd_data);
      end
      @(negedge clk);
      wb_ack = 1'b0;
      nChecks++;
      if ({err, wb_cyc, rd_valid, rd_last} !== 4'b0011 || rd_data !== 32'hCAFE0002) begin
         nFails++; $display("FAIL race_end: err/cyc/rdv/last %b data %h expected 0011/cafe0002", {err, wb_cyc, rd_valid, rd_last}, rd_data);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_burst();
      int extra = 0;
      issueReq(1'b0, 26'h500, 4'd8);
      wb_ack  = 1'b1;
      wb_dato = 32'h55550000;
      @(negedge clk);
      nChecks++;
      if (wb_addr !== 26'h504 || rd_valid !== 1'b1) begin nFails++; $display("FAIL rstmid_beat2: addr %h rdv %b expected 504/1", wb_addr, rd_valid); end
      wb_dato = 32'h55550001;
      rst     = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      wb_ack = 1'b0;
      nChecks++;
      if ({wb_cyc, wb_stb, rd_valid, rd_last, err, req_ready, wr_ready} !== 7'b0 || wb_addr !== 26'h0 || wb_cti !== 3'b000) begin
         nFails++; $display("FAIL rstmid_clear: ctrl %b addr %h cti %b expected 0000000/0/000",
                            {wb_cyc, wb_stb, rd_valid, rd_last, err, req_ready, wr_ready}, wb_addr, wb_cti);
      end
      @(negedge clk);
      nChecks++;
      if (req_ready !== 1'b1) begin nFails++; $display("FAIL rstmid_ready: got %b expected 1", req_ready); end
      issueReq(1'b0, 26'h600, 4'd0);
      nChecks++;
      if (wb_stb !== 1'b1 || wb_addr !== 26'h600 || wb_cti !== 3'b000) begin
         nFails++; $display("FAIL rstmid_new: stb %b addr %h cti %b expected 1/600/000", wb_stb, wb_addr, wb_cti);
      end
      wb_ack  = 1'b1;
      wb_dato = 32'h66666666;
      @(negedge clk);
      wb_ack = 1'b0;
      nChecks++;
      if (rd_valid !== 1'b1 || rd_last !== 1'b1 || rd_data !== 32'h66666666 || wb_cyc !== 1'b0) begin
         nFails++; $display("FAIL rstmid_newrd: rdv %b last %b data %h cyc %b expected 1/1/66666666/0", rd_valid, rd_last, rd_data, wb_cyc);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rd_valid !== 1'b0) extra++;
      end
      nChecks++;
      if (extra != 0) begin nFails++; $display("FAIL rstmid_stray: %0d stray rd_valid expected 0", extra); end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_bl = '0;
      wr_valid = 1'b0; wr_data = '0; wr_sel = '0; wb_ack = 1'b0; wb_dato = '0;
      test_reset();
      test_single_read();
      test_burst_read();
      test_burst_write();
      test_addr_wrap();
      test_timeout();
      test_timeout_ack_race();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
